// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared types and width helpers for the EEPROM page array core.
package eeprom_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PROG = 1'b1
  } state_e;

  // Word address width for the whole array.
  function automatic int addr_w(input int page_bytes, input int num_pages);
    return $clog2(page_bytes * num_pages);
  endfunction

  // Byte offset width inside one page.
  function automatic int off_w(input int page_bytes);
    return $clog2(page_bytes);
  endfunction

  // Width of the write-cycle down-counter (must hold TWR_CYCLES itself).
  function automatic int cnt_w(input int twr_cycles);
    return $clog2(twr_cycles + 1);
  endfunction

endpackage

// File: rtl/eeprom_page_buf.sv
// eeprom_page_buf: page write buffer with a per-byte valid mask and the
// wrapping in-page offset counter. The offset is also the low part of the
// array read pointer; wrap tells the top when a read carries into the page.
module eeprom_page_buf import eeprom_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int PAGE_BYTES = 8,
  localparam int OFF_W     = off_w(PAGE_BYTES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [OFF_W-1:0]             load_off,
  input  logic                         wr,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         rd_inc,
  input  logic                         clr,
  output logic [OFF_W-1:0]             offset,
  output logic                         wrap,
  output logic [PAGE_BYTES*DATA_W-1:0] buf_data,
  output logic [PAGE_BYTES-1:0]        mask
);

  logic [OFF_W-1:0]                   off_q;
  logic [PAGE_BYTES-1:0]              mask_q;
  logic [PAGE_BYTES-1:0][DATA_W-1:0]  buf_q;
  logic [PAGE_BYTES-1:0]              wr_bit;

  assign wr_bit   = {{(PAGE_BYTES-1){1'b0}}, 1'b1} << off_q;
  assign offset   = off_q;
  assign wrap     = &off_q;
  assign buf_data = buf_q;
  assign mask     = mask_q;

  // Offset counter and byte-valid mask; a clear (commit done or discard) wins
  // over a same-cycle write so discarded data never reaches the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      mask_q <= '0;
    end else begin
      if (load)
        off_q <= load_off;
      else if (wr || rd_inc)
        off_q <= off_q + OFF_W'(1);

      if (load || clr)
        mask_q <= '0;
      else if (wr)
        mask_q <= mask_q | wr_bit;
    end
  end

  // Buffer bytes need no reset: only bytes flagged in the mask are ever used.
  always_ff @(posedge clk) begin
    if (wr)
      buf_q[off_q] <= data_i;
  end

endmodule

// File: rtl/eeprom_page_array.sv
// eeprom_page_array: multi-page EEPROM storage core for the I2C slave model.
// Writes collect in a page buffer, commit programs them after a modelled
// write-cycle delay, reads auto-increment across the whole array.
// Build option: define EEPROM_WP_EN to add the wp (write protect) input.
//
// state | meaning
// IDLE  | accepting address loads, buffer writes, reads and commits
// PROG  | write cycle running; requests are refused with nack
module eeprom_page_array import eeprom_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int PAGE_BYTES = 8,
  parameter int NUM_PAGES  = 32,
  parameter int TWR_CYCLES = 16,
  localparam int ADDR_W    = addr_w(PAGE_BYTES, NUM_PAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_o,
  input  logic              commit,
  output logic              busy,
`ifdef EEPROM_WP_EN
  input  logic              wp,
`endif
  output logic              nack
);

  localparam int OFF_W  = off_w(PAGE_BYTES);
  localparam int PAGE_W = ADDR_W - OFF_W;
  localparam int CNT_W  = cnt_w(TWR_CYCLES);
  localparam int DEPTH  = PAGE_BYTES * NUM_PAGES;

  state_e                            state;
  logic [CNT_W-1:0]                  cnt;
  logic [PAGE_W-1:0]                 page_q;
  logic [PAGE_W-1:0]                 buf_page;
  logic [DATA_W-1:0]                 mem [0:DEPTH-1];

  logic [OFF_W-1:0]                  offset;
  logic                              wrap;
  logic [PAGE_BYTES-1:0][DATA_W-1:0] buf_data;
  logic [PAGE_BYTES-1:0]             mask;
  logic [PAGE_BYTES-1:0]             wr_bit;
  logic [PAGE_BYTES-1:0]             mask_next;
  logic [ADDR_W-1:0]                 ptr;

  logic idle, acc_ld, acc_wr, acc_rd;
  logic commit_go, commit_drop, prog_done, wp_act;

`ifdef EEPROM_WP_EN
  assign wp_act = wp;
`else
  assign wp_act = 1'b0;
`endif

  assign idle   = (state == IDLE);
  assign acc_ld = idle & addr_load;
  assign acc_wr = idle & ~addr_load & wr_en;
  assign acc_rd = idle & ~addr_load & ~wr_en & rd_en;
  assign ptr    = {page_q, offset};

  // Commit looks at the mask as it will be after any same-cycle write.
  assign wr_bit      = {{(PAGE_BYTES-1){1'b0}}, 1'b1} << offset;
  assign mask_next   = acc_ld ? '0 : (mask | (acc_wr ? wr_bit : '0));
  assign commit_go   = idle & commit & (|mask_next) & ~wp_act;
  assign commit_drop = idle & commit & wp_act;
  assign prog_done   = (state == PROG) && (cnt == CNT_W'(1));

  eeprom_page_buf #(
    .DATA_W     (DATA_W),
    .PAGE_BYTES (PAGE_BYTES)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (acc_ld),
    .load_off (addr_i[OFF_W-1:0]),
    .wr       (acc_wr),
    .data_i   (data_i),
    .rd_inc   (acc_rd),
    .clr      (prog_done | commit_drop),
    .offset   (offset),
    .wrap     (wrap),
    .buf_data (buf_data),
    .mask     (mask)
  );

  // Control FSM: pointer page, read data, write-cycle timer, busy and nack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      nack     <= 1'b0;
      data_o   <= '0;
      page_q   <= '0;
      buf_page <= '0;
    end else begin
      nack <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_ld) begin
            page_q   <= addr_i[ADDR_W-1:OFF_W];
            buf_page <= addr_i[ADDR_W-1:OFF_W];
          end
          if (acc_rd) begin
            data_o <= mem[ptr];
            if (wrap)
              page_q <= page_q + PAGE_W'(1);
          end
          if (commit_go) begin
            state <= PROG;
            cnt   <= CNT_W'(TWR_CYCLES);
            busy  <= 1'b1;
          end
        end
        PROG: begin
          cnt  <= cnt - CNT_W'(1);
          nack <= addr_load | wr_en | rd_en;
          if (prog_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array programming: every masked byte lands in the buffered page at once.
  always_ff @(posedge clk) begin
    if (prog_done) begin
      for (int i = 0; i < PAGE_BYTES; i++) begin
        if (mask[i])
          mem[{buf_page, OFF_W'(i)}] <= buf_data[i];
      end
    end
  end

endmodule

// File: tb/tb_eeprom_page_array.sv
// Directed bench for eeprom_page_array with a read-data / nack scoreboard.
module tb_eeprom_page_array;

  localparam int TWR = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       addr_load = 1'b0;
  logic [7:0] addr_i = '0;
  logic       wr_en = 1'b0;
  logic [7:0] data_i = '0;
  logic       rd_en = 1'b0;
  logic       commit = 1'b0;
  logic [7:0] data_o;
  logic       busy;
  logic       nack;
`ifdef EEPROM_WP_EN
  logic       wp = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic rd_mark   = 1'b0;
  logic nack_mark = 1'b0;

  eeprom_page_array #(
    .DATA_W(8), .PAGE_BYTES(8), .NUM_PAGES(32), .TWR_CYCLES(TWR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_load (addr_load),
    .addr_i    (addr_i),
    .wr_en     (wr_en),
    .data_i    (data_i),
    .rd_en     (rd_en),
    .data_o    (data_o),
    .commit    (commit),
    .busy      (busy),
`ifdef EEPROM_WP_EN
    .wp        (wp),
`endif
    .nack      (nack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: captures the driver's marks at the edge, checks outputs mid-cycle.
  always begin : mon
    logic p, nk;
    logic [7:0] e;
    @(posedge clk);
    p  = rd_mark;
    nk = nack_mark;
    @(negedge clk);
    if (rst_n) begin
      chk("nack", 32'(nack), 32'(nk));
      if (p) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got %0h want none", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(data_o), 32'(e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    addr_load = 1'b0; wr_en = 1'b0; rd_en = 1'b0; commit = 1'b0;
    rd_mark = 1'b0; nack_mark = 1'b0;
  endtask

  task automatic load(input logic [7:0] a);
    addr_load = 1'b1; addr_i = a; step();
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; data_i = d; step();
  endtask

  task automatic rd(input logic [7:0] e);
    rd_en = 1'b1; rd_mark = 1'b1; exp_q.push_back(e); step();
  endtask

  task automatic busy_count(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_commit(input bit exp_busy);
    int n;
    commit = 1'b1;
    step();
    if (exp_busy) begin
      busy_count(n);
      chk("busy_len", n, TWR);
    end else begin
      chk("no_busy0", 32'(busy), 0);
      step();
      chk("no_busy1", 32'(busy), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_nack", 32'(nack), 0);
    rst_n = 1'b1;
    step();

    // prefill page 0x08
    load(8'h08);
    for (int i = 0; i < 8; i++) wr(8'hB0 + 8'(i));
    do_commit(1'b1);

    // write and read back
    load(8'h10);
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    do_commit(1'b1);
    load(8'h10);
    rd(8'hA1); rd(8'hA2); rd(8'hA3);

    // page roll-over inside page 0x08, then read on into page 0x10
    load(8'h0E);
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    do_commit(1'b1);
    load(8'h08);
    rd(8'h03); rd(8'h04); rd(8'hB2); rd(8'hB3);
    rd(8'hB4); rd(8'hB5); rd(8'h01); rd(8'h02);
    rd(8'hA1);

    // empty commit and array wrap
    load(8'hFF); wr(8'hEE); do_commit(1'b1);
    load(8'h00); wr(8'h11); do_commit(1'b1);
    do_commit(1'b0);
    load(8'hFF);
    rd(8'hEE); rd(8'h11);

    // busy polling
    load(8'h40);
    for (int i = 0; i < 8; i++) wr(8'hC0 + 8'(i));
    do_commit(1'b1);
    load(8'h40);
    rd(8'hC0);
    load(8'h44);
    wr(8'hD4); wr(8'hD5);
    commit = 1'b1; step();
    rd_en = 1'b1; nack_mark = 1'b1; step();
    step();
    addr_load = 1'b1; addr_i = 8'h00; nack_mark = 1'b1; step();
    commit = 1'b1; step();
    wr_en = 1'b1; data_i = 8'hEE; nack_mark = 1'b1; step();
    chk("hold_data", 32'(data_o), 'hC0);
    busy_count(n);
    chk("poll_busy_len", n + 5, TWR);
    rd(8'hC6); rd(8'hC7);
    load(8'h44);
    rd(8'hD4); rd(8'hD5);

    // reset in the fifth write-cycle clock
    load(8'h20); wr(8'h77); do_commit(1'b1);
    load(8'h20); rd(8'h77);
    load(8'h20); wr(8'h55);
    commit = 1'b1; step();
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_data", 32'(data_o), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_commit(1'b0);
    load(8'h20); rd(8'h77);

`ifdef EEPROM_WP_EN
    load(8'h30); wr(8'h33); do_commit(1'b1);
    wp = 1'b1;
    load(8'h30); wr(8'h5A); do_commit(1'b0);
    load(8'h30); rd(8'h33);
    wp = 1'b0;
    load(8'h30); wr(8'h5A); do_commit(1'b1);
    load(8'h30); rd(8'h5A);
`endif

    step(); step();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
